fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// buffers responses in a DEPTH-entry queue. Optional FETCH_BYPASS_EN forwards a response straight to decode.
module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
);

  localparam int unsigned           PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned           CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] q_pc_mem    [DEPTH];
  logic [DATA_WIDTH-1:0] q_instr_mem [DEPTH];

  logic [DATA_WIDTH-1:0] redir_pc_c;
  logic                  bypass_c;
  logic                  issue_room_c;
  logic                  push_c;
  logic                  pop_c;

  // Issue, presentation and queue bookkeeping; redirect overrides everything but reset.
  always_comb begin
    redir_pc_c   = redirect_pc & ALIGN_MASK;
    bypass_c     = 1'b0;
`ifdef FETCH_BYPASS_EN
    bypass_c     = inflight_q && (count_q == '0) && !redirect_valid;
`endif
    // In-flight response already owns a slot, so it can never overflow the queue.
    issue_room_c = (count_q + CNT_W'(inflight_q)) < DEPTH_C;

    imem_req    = 1'b0;
    imem_addr   = RESET_PC;
    instr_valid = 1'b0;
    instr       = '0;
    instr_pc    = '0;
    if (!rst) begin
      if (redirect_valid) begin
        imem_req  = 1'b1;
        imem_addr = redir_pc_c;
      end else begin
        imem_req  = issue_room_c;
        imem_addr = pc_q;
      end
      instr_valid = !redirect_valid && ((count_q != '0) || bypass_c);
      instr       = q_instr_mem[rd_ptr_q];
      instr_pc    = q_pc_mem[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
      if (bypass_c) begin
        instr    = imem_rdata;
        instr_pc = inflight_pc_q;
      end
`endif
    end

    pop_c  = instr_valid && instr_ready && !bypass_c;
    push_c = !rst && inflight_q && !redirect_valid && !(bypass_c && instr_ready);

    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      pc_d          = redir_pc_c + STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = redir_pc_c;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      if (imem_req) begin
        pc_d          = pc_q + STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end else begin
        inflight_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_pc_mem[i]    <= '0;
        q_instr_mem[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push_c) begin
        q_pc_mem[wr_ptr_q]    <= inflight_pc_q;
        q_instr_mem[wr_ptr_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory model returns word = address one cycle after a request.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'hBAD0_BAD0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int vecs = 0;
  int errs = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_req ? imem_addr : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: advance past the edge, apply inputs, let combinational outputs settle.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
  endtask

  // Step with instr_ready high until a valid instruction is seen, then check it.
  task automatic expect_next(input string tag, input logic [31:0] exp_pc, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (!found) begin
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        n++;
        if (instr_valid) begin
          found = 1'b1;
          chk({tag, "_pc"}, instr_pc, exp_pc);
          chk({tag, "_instr"}, instr, exp_pc);
        end
      end
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
  endtask

  logic [31:0] exp_pcs [5];
  int n;

  initial begin
    exp_pcs[0] = 32'h0; exp_pcs[1] = 32'h4; exp_pcs[2] = 32'h8;
    exp_pcs[3] = 32'hC; exp_pcs[4] = 32'h10;

    // Reset state
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // Streaming at one per cycle
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("stream_req", 32'(imem_req), 32'd1);
      chk("stream_addr", imem_addr, 32'(4 * k));
      if (k >= LAT) begin
        chk("stream_valid", 32'(instr_valid), 32'd1);
        chk("stream_pc", instr_pc, 32'(4 * (k - LAT)));
        chk("stream_instr", instr, 32'(4 * (k - LAT)));
      end else begin
        chk("stream_early_valid", 32'(instr_valid), 32'd0);
      end
    end

    // Backpressure fills queue, then drains in order
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("full_req", 32'(imem_req), 32'(k < 4));
      if (k < 4) chk("full_addr", imem_addr, 32'(4 * k));
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk("drain_valid", 32'(instr_valid), 32'd1);
      chk("drain_pc", instr_pc, exp_pcs[k]);
      if (k == 0) chk("drain_req0", 32'(imem_req), 32'd0);
      if (k == 1) begin
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h10);
      end
    end

    // Redirect with 3 queued and 1 in flight
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h103, 1'b0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    expect_next("redir_first", 32'h100, n);
    chk("redir_lat", 32'(n), 32'(LAT));
    expect_next("redir_second", 32'h104, n);
    expect_next("redir_third", 32'h108, n);

    // Redirect on a full queue with consumer ready
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk("fullredir_valid", 32'(instr_valid), 32'd0);
    chk("fullredir_addr", imem_addr, 32'h200);
    expect_next("fullredir_first", 32'h200, n);
    expect_next("fullredir_second", 32'h204, n);

    // Reset pulse mid-stream drops queued 0x300 region
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 32'h300, 1'b0);
    chk("pre_rst_addr", imem_addr, 32'h300);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("pre_rst_pc", instr_pc, 32'h300);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_pc", instr_pc, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    chk("postrst_valid", 32'(instr_valid), 32'd0);
    chk("postrst_addr", imem_addr, 32'h0);
    expect_next("postrst_first", 32'h0, n);
    expect_next("postrst_second", 32'h4, n);

    // PC wrap at top of address space
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr1", imem_addr, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr2", imem_addr, 32'h4);
    expect_next("wrap_first", 32'hFFFF_FFFC, n);
    expect_next("wrap_second", 32'h0, n);
    expect_next("wrap_third", 32'h4, n);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
